// File: rtl/iob_eth_frame_builder.sv
`default_nettype none
// ============================================================================
// Module   : iob_eth_frame_builder
// Purpose  : Builds an Ethernet frame into the TX buffer write port. It writes
//            a 14-byte MAC header (dst MAC, own MAC, ethertype), then a
//            streamed payload, then optional zero padding. It also drives the
//            transmitter byte-count/send handshake.
// Revision : 1.0 - initial release
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   start                    one-cycle frame request (sampled in IDLE only)
//   dst_mac, ethertype       header fields, captured on an accepted start
//   s_data/s_valid/s_last    payload byte stream, s_ready = byte accepted
//   buf_wen/addr/wdata       registered TX buffer write port
//   tx_ready                 transmitter idle (already in clk domain)
//   send, nbytes             send request level and frame length
//   busy, done, overflow     status (done/overflow are one-cycle pulses)
//
// Build option
//   IOB_ETH_BUILDER_PAD_EN   zero-pad frames shorter than 60 bytes
// ============================================================================
module iob_eth_frame_builder #(
  parameter logic [47:0] ETH_MAC_ADDR = 48'h01606e11020f,
  parameter int          BUF_ADDR_W   = 11,
  parameter int          MAX_PAYLOAD  = 1500
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [47:0]           dst_mac,
  input  logic [15:0]           ethertype,
  input  logic [7:0]            s_data,
  input  logic                  s_valid,
  input  logic                  s_last,
  output logic                  s_ready,
  output logic                  buf_wen,
  output logic [BUF_ADDR_W-1:0] buf_addr,
  output logic [7:0]            buf_wdata,
  input  logic                  tx_ready,
  output logic                  send,
  output logic [BUF_ADDR_W-1:0] nbytes,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HDR     = 3'd1,
    S_PAYLOAD = 3'd2,
    S_DRAIN   = 3'd3,
    S_PAD     = 3'd4,
    S_WAIT_TX = 3'd5,
    S_SEND    = 3'd6
  } state_t;

  // Write pointer value at which MAX_PAYLOAD bytes are already stored; the
  // next accepted byte is the overflowing one.
  localparam logic [BUF_ADDR_W-1:0] c_ovf_ptr  = BUF_ADDR_W'(14 + MAX_PAYLOAD);
  localparam logic [BUF_ADDR_W-1:0] c_hdr_last = BUF_ADDR_W'(13);
`ifdef IOB_ETH_BUILDER_PAD_EN
  localparam logic [BUF_ADDR_W-1:0] c_min_len  = BUF_ADDR_W'(60);
`endif

  state_t                r_state;
  logic [47:0]           r_dst;
  logic [15:0]           r_etype;
  logic [BUF_ADDR_W-1:0] r_wptr;      // next buffer address to write
  logic                  r_buf_wen;
  logic [BUF_ADDR_W-1:0] r_buf_addr;
  logic [7:0]            r_buf_wdata;
  logic                  r_send;
  logic [BUF_ADDR_W-1:0] r_nbytes;
  logic                  r_done;
  logic                  r_overflow;

  logic [BUF_ADDR_W-1:0] w_len_next;  // frame length once r_wptr is written

  assign w_len_next = r_wptr + 1'b1;

  // Header byte idx (0..13) in transmit order, MSB byte of each field first.
  function automatic logic [7:0] f_hdr_byte(input logic [47:0] dst,
                                            input logic [15:0] et,
                                            input logic [3:0]  idx);
    logic [111:0] v_hdr;
    v_hdr = {dst, ETH_MAC_ADDR, et} << (8 * idx);
    return v_hdr[111:104];
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_dst       <= '0;
      r_etype     <= '0;
      r_wptr      <= '0;
      r_buf_wen   <= 1'b0;
      r_buf_addr  <= '0;
      r_buf_wdata <= '0;
      r_send      <= 1'b0;
      r_nbytes    <= '0;
      r_done      <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_buf_wen  <= 1'b0;
      r_done     <= 1'b0;
      r_overflow <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            // Header byte 0 is issued straight from the inputs so the write
            // lands the cycle after the accepted start.
            r_dst       <= dst_mac;
            r_etype     <= ethertype;
            r_buf_wen   <= 1'b1;
            r_buf_addr  <= '0;
            r_buf_wdata <= dst_mac[47:40];
            r_wptr      <= BUF_ADDR_W'(1);
            r_state     <= S_HDR;
          end
        end
        S_HDR: begin
          r_buf_wen   <= 1'b1;
          r_buf_addr  <= r_wptr;
          r_buf_wdata <= f_hdr_byte(r_dst, r_etype, r_wptr[3:0]);
          r_wptr      <= w_len_next;
          if (r_wptr == c_hdr_last) r_state <= S_PAYLOAD;
        end
        S_PAYLOAD: begin
          if (s_valid) begin
            if (r_wptr == c_ovf_ptr) begin
              r_overflow <= 1'b1;
              r_state    <= s_last ? S_IDLE : S_DRAIN;
            end else begin
              r_buf_wen   <= 1'b1;
              r_buf_addr  <= r_wptr;
              r_buf_wdata <= s_data;
              r_wptr      <= w_len_next;
              if (s_last) begin
`ifdef IOB_ETH_BUILDER_PAD_EN
                if (w_len_next >= c_min_len) begin
                  r_nbytes <= w_len_next;
                  r_state  <= S_WAIT_TX;
                end else begin
                  r_state  <= S_PAD;
                end
`else
                r_nbytes <= w_len_next;
                r_state  <= S_WAIT_TX;
`endif
              end
            end
          end
        end
        S_DRAIN: begin
          if (s_valid && s_last) r_state <= S_IDLE;
        end
`ifdef IOB_ETH_BUILDER_PAD_EN
        S_PAD: begin
          r_buf_wen   <= 1'b1;
          r_buf_addr  <= r_wptr;
          r_buf_wdata <= 8'h00;
          r_wptr      <= w_len_next;
          if (w_len_next == c_min_len) begin
            r_nbytes <= c_min_len;
            r_state  <= S_WAIT_TX;
          end
        end
`endif
        S_WAIT_TX: begin
          if (tx_ready) begin
            r_send  <= 1'b1;
            r_state <= S_SEND;
          end
        end
        S_SEND: begin
          // Hold the request until the transmitter shows it has taken it.
          if (!tx_ready) begin
            r_send  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign s_ready   = (r_state == S_PAYLOAD) || (r_state == S_DRAIN);
  assign busy      = (r_state != S_IDLE);
  assign buf_wen   = r_buf_wen;
  assign buf_addr  = r_buf_addr;
  assign buf_wdata = r_buf_wdata;
  assign send      = r_send;
  assign nbytes    = r_nbytes;
  assign done      = r_done;
  assign overflow  = r_overflow;

endmodule
`default_nettype wire

// File: doc/iob_eth_frame_builder.md
Name: iob_eth_frame_builder

Overview:
- Host-clock-domain stage directly upstream of the Ethernet TX buffer and transmitter.
- Builds a frame into the TX buffer write port: 14-byte MAC header (dst MAC, own MAC, ethertype) followed by a streamed payload, with optional zero padding.
- Drives the transmitter's byte-count/send handshake, replacing per-byte CPU writes.

Parameters:
- ETH_MAC_ADDR, 48'h01606e11020f, own (source) MAC address, MSB byte transmitted first
- BUF_ADDR_W, 11, TX buffer address width
- MAX_PAYLOAD, 1500, maximum payload bytes per frame

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle frame request; sampled only in IDLE
- dst_mac  in  48  destination MAC; captured on accepted start
- ethertype  in  16  ethertype/length; captured on accepted start
- s_data  in  8  payload byte
- s_valid  in  1  payload byte valid
- s_last  in  1  marks last payload byte
- s_ready  out  1  builder accepts payload byte
- buf_wen  out  1  TX buffer write enable
- buf_addr  out  BUF_ADDR_W  TX buffer write address
- buf_wdata  out  8  TX buffer write data
- tx_ready  in  1  transmitter idle (already synchronised to clk)
- send  out  1  send request level to transmitter
- nbytes  out  BUF_ADDR_W  frame length in bytes (header + payload + pad)
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when frame handed off
- overflow  out  1  one-cycle pulse when a frame is dropped for exceeding MAX_PAYLOAD

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset, including mid-frame: state IDLE; s_ready, buf_wen, send, busy, done and overflow are 0; buf_addr, buf_wdata and nbytes are 0. Bytes already in the buffer are left as is and no send is issued.
- Write-port outputs (buf_wen, buf_addr, buf_wdata) are registered: an event in cycle t appears at the write port in cycle t+1.
- States: IDLE, HDR, PAYLOAD, DRAIN, PAD, WAIT_TX, SEND.
- IDLE:
  - start=1 captures dst_mac and ethertype, clears the byte counter and moves to HDR.
  - start in any other state is ignored.
- HDR:
  - 14 cycles, one byte per cycle, addresses 0..13.
  - Byte order: dst_mac[47:40] .. dst_mac[7:0], then ETH_MAC_ADDR[47:40] .. [7:0], then ethertype[15:8], ethertype[7:0].
  - After byte 13, go to PAYLOAD.
  - A start accepted in cycle 0 gives writes in cycles 1..14.
- PAYLOAD:
  - s_ready=1.
  - Each cycle with s_valid=1 writes s_data at address 14+count and increments count.
  - Gaps with s_valid=0 are allowed.
  - s_last accepted, with payload count <= MAX_PAYLOAD: go to PAD if the optional feature is compiled in, else WAIT_TX.
  - Accepting byte MAX_PAYLOAD+1 (not written): pulse overflow and go to DRAIN.
- DRAIN:
  - s_ready=1; bytes are discarded with no writes.
  - On s_last accepted, return to IDLE with no send.
  - If the overflowing byte itself carried s_last, go straight to IDLE.
- WAIT_TX:
  - nbytes is registered on entry and held stable until the next accepted start.
  - Wait for tx_ready=1, then go to SEND.
- SEND:
  - send=1 until tx_ready=0 is observed (transmitter acknowledged).
  - Then send=0, done=1 for one cycle, go to IDLE.
  - send never drops before tx_ready falls.
- s_ready is 0 in every state except PAYLOAD and DRAIN.
- nbytes = 14 + payload count (+ pad). Maximum is 1514, which fits in 11 bits. Address never wraps.
- Zero-length payload (first accepted byte carries s_last) is legal.

Optional Feature:
- Macro: IOB_ETH_BUILDER_PAD_EN.
- Defined:
  - PAD state writes 8'h00 at successive addresses, one per cycle, until the frame reaches 60 bytes; then go to WAIT_TX, with nbytes >= 60.
  - If the frame is already >= 60 bytes, PAD lasts zero cycles.
- Undefined: PAD is unreachable and nbytes = 14 + payload.

Test Plan:
- Reset, then start with dst_mac=48'hFFFFFFFFFFFF, ethertype=16'h0800, 4-byte payload 11,22,33,44 and tx_ready=1 -> writes at addresses 0..17 with bytes FF x6, 01 60 6E 11 02 0F, 08 00, 11 22 33 44; then padded to address 59 with 00 and nbytes=60 (PAD_EN) or nbytes=18 (no PAD_EN).
- Same frame with tx_ready=0 for 20 cycles -> send stays 0 and state is held; when tx_ready rises, send=1; when tx_ready falls, send drops next cycle and done pulses once.
- 1500-byte payload with s_valid toggling every other cycle -> last write at address 1513, nbytes=1514, no overflow.
- 1502-byte payload -> overflow pulses on byte 1501, no write above address 1513, send never asserted, busy returns to 0 after s_last.
- rst asserted during payload byte 5 -> next cycle all outputs 0 and IDLE; a new start produces a normal frame.
- Second start pulsed during HDR of a frame -> ignored; exactly one done pulse.
